// File: rtl/fejkon_led_pkg.sv
// Shared types and constants for the fejkon LED controller.
// Lamp-test logic is present only when FEJKON_LED_CTRL_LAMPTEST_EN is defined.
package fejkon_led_pkg;

   typedef enum logic [1:0] {
      MODE_FOLLOW = 2'd0,
      MODE_OFF    = 2'd1,
      MODE_ON     = 2'd2,
      MODE_BLINK  = 2'd3
   } led_mode_t;

   typedef enum logic [1:0] {
      LT_IDLE   = 2'd0,
      LT_WALK   = 2'd1,
      LT_ALL_ON = 2'd2
   } lt_state_t;

   localparam logic [1:0]  ADDR_MODE   = 2'd0;
   localparam logic [1:0]  ADDR_CTRL   = 2'd1;
   localparam logic [1:0]  ADDR_STATUS = 2'd2;
   localparam logic [1:0]  ADDR_ID     = 2'd3;
   localparam logic [31:0] ID_VALUE    = 32'h4C45_4443;

   function automatic logic led_mode_bit(input led_mode_t m, input logic st, input logic ph);
      case (m)
         MODE_FOLLOW: return st;
         MODE_OFF:    return 1'b0;
         MODE_ON:     return 1'b1;
         default:     return ph;
      endcase
   endfunction

endpackage

// File: rtl/fejkon_led_tick.sv
// Reloadable down-counter; tick is high for the one cycle the count sits at 0
// while enabled, and the counter reloads to Cycles-1 on that cycle or on load.
module fejkon_led_tick #(
   parameter int unsigned Cycles     = 10,
   parameter int unsigned ResetCount = Cycles - 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic load,
   output logic tick
);

   localparam int unsigned W = (Cycles > 1) ? $clog2(Cycles) : 1;
   localparam logic [W-1:0] Reload = W'(Cycles - 1);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= W'(ResetCount);
      end else if (load || tick) begin
         cnt <= Reload;
      end else if (en) begin
         cnt <= cnt - W'(1);
      end
   end

endmodule

// File: rtl/fejkon_led_ctrl.sv
// Avalon-MM LED controller: per-LED follow/off/on/blink modes, global enable,
// optional lamp test (define FEJKON_LED_CTRL_LAMPTEST_EN to build it in).
module fejkon_led_ctrl
   import fejkon_led_pkg::*;
#(
   parameter int unsigned ReferenceClock = 50000000,
   parameter int unsigned BlinkCycles    = ReferenceClock / 10,
   parameter int unsigned StepCycles     = ReferenceClock / 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   input  logic [7:0]  status_in,
   output logic [7:0]  led
);

   logic [7:0]  sync1, sync2;
   logic [15:0] mode;
   logic        enable;
   logic        blink_phase;
   logic        blink_tick;
   logic [7:0]  mode_out;
   logic [7:0]  led_nxt;
   logic [31:0] rd_mux;
   logic        lt_busy;
   logic [7:0]  lt_pattern;

   logic wr_mode, wr_ctrl;
   assign wr_mode = avs_write && (avs_address == ADDR_MODE);
   assign wr_ctrl = avs_write && (avs_address == ADDR_CTRL);

   logic unused_wdata;
   assign unused_wdata = ^avs_writedata[31:16];

   fejkon_led_tick #(.Cycles(BlinkCycles)) u_blink_tick (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .load  (1'b0),
      .tick  (blink_tick)
   );

`ifdef FEJKON_LED_CTRL_LAMPTEST_EN
   lt_state_t lt_state;
   logic      lt_start, lt_abort, step_tick;

   assign lt_start = wr_ctrl && avs_writedata[0];
   assign lt_abort = wr_ctrl && avs_writedata[2];
   assign lt_busy  = (lt_state != LT_IDLE);

   // The step counter restarts on an accepted start so every step is full length.
   fejkon_led_tick #(.Cycles(StepCycles), .ResetCount(0)) u_step_tick (
      .clk   (clk),
      .reset (reset),
      .en    (lt_busy),
      .load  (lt_start && !lt_abort && !lt_busy),
      .tick  (step_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lt_state   <= LT_IDLE;
         lt_pattern <= 8'h00;
      end else if (lt_abort) begin
         lt_state   <= LT_IDLE;
         lt_pattern <= 8'h00;
      end else begin
         case (lt_state)
            LT_IDLE: if (lt_start) begin
               lt_state   <= LT_WALK;
               lt_pattern <= 8'h01;
            end
            LT_WALK: if (step_tick) begin
               if (lt_pattern == 8'h80) begin
                  lt_state   <= LT_ALL_ON;
                  lt_pattern <= 8'hFF;
               end else begin
                  lt_pattern <= lt_pattern << 1;
               end
            end
            LT_ALL_ON: if (step_tick) begin
               lt_state   <= LT_IDLE;
               lt_pattern <= 8'h00;
            end
            default: begin
               lt_state   <= LT_IDLE;
               lt_pattern <= 8'h00;
            end
         endcase
      end
   end
`else
   logic unused_ctrl;
   assign unused_ctrl = avs_writedata[0] ^ avs_writedata[2];
   assign lt_busy    = 1'b0;
   assign lt_pattern = 8'h00;
`endif

   for (genvar i = 0; i < 8; i++) begin : g_led
      assign mode_out[i] = led_mode_bit(led_mode_t'(mode[2*i +: 2]), sync2[i], blink_phase);
   end

   always_comb begin
      led_nxt = 8'h00;
      if (enable) led_nxt = lt_busy ? lt_pattern : mode_out;
   end

   always_comb begin
      rd_mux = 32'h0;
      case (avs_address)
         ADDR_MODE:   rd_mux = {16'h0, mode};
         ADDR_CTRL:   rd_mux = {30'h0, enable, 1'b0};
         ADDR_STATUS: rd_mux = {8'h0, led, sync2, 7'h0, lt_busy};
         ADDR_ID:     rd_mux = ID_VALUE;
         default:     rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1        <= 8'h00;
         sync2        <= 8'h00;
         mode         <= 16'h0000;
         enable       <= 1'b1;
         blink_phase  <= 1'b1;
         led          <= 8'h00;
         avs_readdata <= 32'h0;
      end else begin
         sync1 <= status_in;
         sync2 <= sync1;
         if (wr_mode) mode <= avs_writedata[15:0];
         if (wr_ctrl) enable <= avs_writedata[1];
         if (blink_tick) blink_phase <= ~blink_phase;
         led          <= led_nxt;
         avs_readdata <= avs_read ? rd_mux : 32'h0;
      end
   end

endmodule

// File: tb/tb_fejkon_led_ctrl.sv
// Directed bench for fejkon_led_ctrl (ReferenceClock=100, BlinkCycles=10, StepCycles=12).
// Lamp-test vectors run when FEJKON_LED_CTRL_LAMPTEST_EN is defined; otherwise start must be inert.
module tb_fejkon_led_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic [7:0]  status_in;
   logic [7:0]  led;

   int n_chk = 0;
   int n_err = 0;

   fejkon_led_ctrl #(.ReferenceClock(100), .BlinkCycles(10), .StepCycles(12)) dut (
      .clk           (clk),
      .reset         (reset),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .status_in     (status_in),
      .led           (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(posedge clk); #1;
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      avs_address = a; avs_read = 1'b1;
      @(posedge clk); #1;
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   // Expected led k edges after the start write, with post-test MODE output mo.
   function automatic logic [7:0] lt_exp(input int k, input logic [7:0] mo);
      logic [7:0] one;
      one = 8'h01;
      if (k <= 96)  return one << ((k - 1) / 12);
      if (k <= 108) return 8'hFF;
      return mo;
   endfunction

   initial begin
      logic [31:0] d;
      reset = 1'b1; avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0;
      avs_writedata = 32'h0; status_in = 8'h00;
      step(3);
      check("reset_led", {24'h0, led}, 32'h0);
      check("reset_rdata", avs_readdata, 32'h0);
      reset = 1'b0;

      // Blink from reset: MODE written on edge 1; phase starts 1, flips every 10 edges.
      wr(2'd0, 32'h0000FFFF);
      step(1);  check("blink_e2",  {24'h0, led}, 32'hFF);
      step(8);  check("blink_e10", {24'h0, led}, 32'hFF);
      step(1);  check("blink_e11", {24'h0, led}, 32'h00);
      step(9);  check("blink_e20", {24'h0, led}, 32'h00);
      step(1);  check("blink_e21", {24'h0, led}, 32'hFF);

      // Follow mode: 3-cycle status_in -> led latency.
      wr(2'd0, 32'h0);
      status_in = 8'hA5;
      step(2);  check("sync_lat2", {24'h0, led}, 32'h00);
      step(1);  check("sync_lat3", {24'h0, led}, 32'hA5);
      rd(2'd2, d); check("status_a5", d, 32'h00A5A500);

      // Forced modes and global enable.
      status_in = 8'h00;
      step(3);
      wr(2'd0, 32'h0000000A); step(1); check("force_on_on", {24'h0, led}, 32'h03);
      wr(2'd0, 32'h00000009); step(1); check("force_off_on", {24'h0, led}, 32'h02);
      wr(2'd1, 32'h0);        check("en_off_same", {24'h0, led}, 32'h02);
      step(1);                check("en_off_next", {24'h0, led}, 32'h00);
      rd(2'd1, d);            check("ctrl_en0", d, 32'h0);
      wr(2'd1, 32'h2);
      rd(2'd1, d);            check("ctrl_en1", d, 32'h2);

      // Register map: ID, read-only registers, unmapped MODE bits.
      rd(2'd3, d);            check("id", d, 32'h4C454443);
      wr(2'd3, 32'h0);
      rd(2'd3, d);            check("id_after_wr", d, 32'h4C454443);
      wr(2'd2, 32'hFFFFFFFF);
      rd(2'd2, d);            check("status_ro", d, 32'h00020000);
      wr(2'd0, 32'hFFFFFFFF);
      rd(2'd0, d);            check("mode_width", d, 32'h0000FFFF);

      wr(2'd0, 32'h0);
      status_in = 8'h3C;
      step(3);                check("follow_3c", {24'h0, led}, 32'h3C);

`ifdef FEJKON_LED_CTRL_LAMPTEST_EN
      // Full lamp test; MODE rewritten mid-test only shows after the test.
      wr(2'd1, 32'h3);
      for (int k = 1; k <= 110; k++) begin
         if (k == 50) wr(2'd0, 32'h2);
         else if (k == 60) begin
            rd(2'd2, d); check("lt_status_busy", d, 32'h00103C01);
         end else step(1);
         if ((k % 12) <= 1 || k >= 108)
            check($sformatf("lt_k%0d", k), {24'h0, led}, {24'h0, lt_exp(k, 8'h3D)});
      end
      rd(2'd2, d);            check("lt_done_status", d, 32'h003D3C00);

      // Restart ignored, then abort at step 3.
      wr(2'd1, 32'h3);
      for (int k = 1; k <= 41; k++) begin
         if (k == 20) wr(2'd1, 32'h3);
         else if (k == 40) wr(2'd1, 32'h6);
         else step(1);
         if (k == 30) check("lt_no_restart", {24'h0, led}, 32'h04);
         if (k == 40) check("lt_abort_edge", {24'h0, led}, 32'h08);
         if (k == 41) check("lt_abort_next", {24'h0, led}, 32'h3D);
      end
      rd(2'd2, d);            check("lt_abort_busy", d, 32'h003D3C00);
      rd(2'd1, d);            check("lt_ctrl_reads", d, 32'h2);

      // Start and abort together: abort wins.
      wr(2'd1, 32'h7);
      rd(2'd2, d);            check("lt_start_abort", d, 32'h003D3C00);

      // Enable cleared mid-test blanks led; test continues.
      wr(2'd1, 32'h3);
      step(5);
      wr(2'd1, 32'h0);
      step(1);                check("lt_blank", {24'h0, led}, 32'h00);
      rd(2'd2, d);            check("lt_blank_busy", d, 32'h00003C01);
      wr(2'd1, 32'h2);
      step(1);                check("lt_unblank", {24'h0, led}, 32'h01);
      step(20);               check("lt_pre_reset", {24'h0, led}, 32'h04);
`else
      wr(2'd1, 32'h3);
      step(2);                check("nolt_led", {24'h0, led}, 32'h3C);
      rd(2'd2, d);            check("nolt_status", d, 32'h003C3C00);
      rd(2'd1, d);            check("nolt_ctrl", d, 32'h2);
      wr(2'd0, 32'h2);
      step(2);
`endif

      // Asynchronous reset blanks led immediately and restores defaults.
      reset = 1'b1;
      #1;                     check("async_reset", {24'h0, led}, 32'h00);
      step(2);
      reset = 1'b0;
      rd(2'd2, d);            check("post_reset_status", d, 32'h0);
      step(2);                check("post_reset_led", {24'h0, led}, 32'h3C);
      rd(2'd2, d);            check("post_reset_idle", d, 32'h003C3C00);
      rd(2'd1, d);            check("post_reset_ctrl", d, 32'h2);
      rd(2'd0, d);            check("post_reset_mode", d, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
